// File: rtl/serial_audio_pkg.sv
// Shared types for the stereo sample scheduler: FSM states and underrun fill policies.
package serial_audio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRIME   = 2'd1,
    LOAD    = 2'd2,
    PRESENT = 2'd3
  } sched_state_e;

  localparam logic FILL_ZERO   = 1'b0;
  localparam logic FILL_REPEAT = 1'b1;

endpackage

// File: rtl/serial_audio_channel_scheduler_if.sv
// Left/right sample inputs and the single interleaved stream towards the encoder.
interface serial_audio_channel_scheduler_if #(
  parameter int unsigned audio_width = 32
);
  logic                   l_valid;
  logic                   l_ready;
  logic [audio_width-1:0] l_audio;
  logic                   r_valid;
  logic                   r_ready;
  logic [audio_width-1:0] r_audio;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_is_left;
  logic [audio_width-1:0] o_audio;

  // Sources and encoder side
  modport master (
    output l_valid, l_audio, r_valid, r_audio, o_ready,
    input  l_ready, r_ready, o_valid, o_is_left, o_audio
  );

  // Scheduler side
  modport slave (
    input  l_valid, l_audio, r_valid, r_audio, o_ready,
    output l_ready, r_ready, o_valid, o_is_left, o_audio
  );
endinterface

// File: rtl/serial_audio_channel_fifo.sv
// Per-channel sample FIFO of depth 2**depth_log2 with synchronous flush and occupancy count.
module serial_audio_channel_fifo #(
  parameter int unsigned audio_width = 32,
  parameter int unsigned depth_log2  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [audio_width-1:0] data_in,
  output logic [audio_width-1:0] data_out,
  output logic [depth_log2:0]    count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned depth = 1 << depth_log2;
  localparam int unsigned cnt_w = depth_log2 + 1;

  logic [audio_width-1:0] mem [depth];
  logic [depth_log2-1:0]  wr_ptr;
  logic [depth_log2-1:0]  rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  assign full     = (count == cnt_w'(depth));
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + depth_log2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + depth_log2'(1);
      count <= count + cnt_w'(do_push) - cnt_w'(do_pop);
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/serial_audio_channel_scheduler.sv
// Interleaves two buffered channels into a strict L,R stream for the encoder, framing starts/stops
// on L+R pairs and filling underruns. SERIAL_AUDIO_SCHEDULER_STATS_EN adds a saturating fill counter.
module serial_audio_channel_scheduler
  import serial_audio_pkg::*;
#(
  parameter int unsigned audio_width     = 32,
  parameter int unsigned fifo_depth_log2 = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic fill_repeat,
  serial_audio_channel_scheduler_if.slave bus,
  output logic fill_strobe
`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
  ,
  output logic [15:0] fill_count
`endif
);
  localparam int unsigned cnt_w = fifo_depth_log2 + 1;

  sched_state_e           state_q, state_d;
  logic                   next_is_left_q, next_is_left_d;
  logic [audio_width-1:0] last_l_q, last_l_d;
  logic [audio_width-1:0] last_r_q, last_r_d;
  logic [audio_width-1:0] o_audio_q, o_audio_d;
  logic                   o_is_left_q, o_is_left_d;
  logic                   o_valid_q, o_valid_d;
  logic                   fill_strobe_q, fill_strobe_d;

  logic                   flush;
  logic                   l_push, l_pop, l_full, l_empty;
  logic                   r_push, r_pop, r_full, r_empty;
  logic [audio_width-1:0] l_head, r_head;
  logic [cnt_w-1:0]       l_count, r_count;

  assign flush       = (state_q == IDLE);
  assign bus.l_ready = !flush && !l_full;
  assign bus.r_ready = !flush && !r_full;
  assign l_push      = bus.l_valid && bus.l_ready;
  assign r_push      = bus.r_valid && bus.r_ready;

  serial_audio_channel_fifo #(.audio_width(audio_width), .depth_log2(fifo_depth_log2)) u_l_fifo (
    .clk(clk), .reset_n(reset_n), .push(l_push), .pop(l_pop), .flush(flush),
    .data_in(bus.l_audio), .data_out(l_head), .count(l_count), .full(l_full), .empty(l_empty)
  );

  serial_audio_channel_fifo #(.audio_width(audio_width), .depth_log2(fifo_depth_log2)) u_r_fifo (
    .clk(clk), .reset_n(reset_n), .push(r_push), .pop(r_pop), .flush(flush),
    .data_in(bus.r_audio), .data_out(r_head), .count(r_count), .full(r_full), .empty(r_empty)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    next_is_left_d = next_is_left_q;
    last_l_d       = last_l_q;
    last_r_d       = last_r_q;
    o_audio_d      = o_audio_q;
    o_is_left_d    = o_is_left_q;
    fill_strobe_d  = 1'b0;
    l_pop          = 1'b0;
    r_pop          = 1'b0;

    case (state_q)
      IDLE: begin
        next_is_left_d = 1'b1;
        last_l_d       = '0;
        last_r_d       = '0;
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable)                                 state_d = IDLE;
        else if ((l_count != '0) && (r_count != '0)) state_d = LOAD;
      end
      LOAD: begin
        o_is_left_d = next_is_left_q;
        state_d     = PRESENT;
        if (next_is_left_q) begin
          if (!l_empty) begin
            l_pop     = 1'b1;
            o_audio_d = l_head;
            last_l_d  = l_head;
          end else begin
            o_audio_d     = (fill_repeat == FILL_ZERO) ? '0 : last_l_q;
            fill_strobe_d = 1'b1;
          end
        end else begin
          if (!r_empty) begin
            r_pop     = 1'b1;
            o_audio_d = r_head;
            last_r_d  = r_head;
          end else begin
            o_audio_d     = (fill_repeat == FILL_ZERO) ? '0 : last_r_q;
            fill_strobe_d = 1'b1;
          end
        end
      end
      PRESENT: begin
        // A stop request only takes effect once the right half of the frame has gone out
        if (bus.o_ready) begin
          next_is_left_d = !next_is_left_q;
          state_d        = (!o_is_left_q && !enable) ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    o_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      next_is_left_q <= 1'b1;
      last_l_q       <= '0;
      last_r_q       <= '0;
      o_audio_q      <= '0;
      o_is_left_q    <= 1'b0;
      o_valid_q      <= 1'b0;
      fill_strobe_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      next_is_left_q <= next_is_left_d;
      last_l_q       <= last_l_d;
      last_r_q       <= last_r_d;
      o_audio_q      <= o_audio_d;
      o_is_left_q    <= o_is_left_d;
      o_valid_q      <= o_valid_d;
      fill_strobe_q  <= fill_strobe_d;
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_is_left = o_is_left_q;
  assign bus.o_audio   = o_audio_q;
  assign fill_strobe   = fill_strobe_q;

`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
  logic [15:0] fill_count_q;

  // Saturating count of fill pulses, cleared each time the scheduler drops back to IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_count_q <= '0;
    end else if ((state_q != IDLE) && (state_d == IDLE)) begin
      fill_count_q <= '0;
    end else if (fill_strobe_q && (fill_count_q != 16'hFFFF)) begin
      fill_count_q <= fill_count_q + 16'd1;
    end
  end

  assign fill_count = fill_count_q;
`endif

endmodule

// File: tb/tb_serial_audio_channel_scheduler.sv
// Self-checking bench for serial_audio_channel_scheduler: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_serial_audio_channel_scheduler;
  import serial_audio_pkg::*;

  localparam int unsigned W         = 32;
  localparam int unsigned FIFO_LOG2 = 1;
  localparam int unsigned DEPTH     = 1 << FIFO_LOG2;

  logic clk = 1'b0;
  logic reset_n;
  logic enable;
  logic fill_repeat;
  logic fill_strobe;
`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
  logic [15:0] fill_count;
`endif

  serial_audio_channel_scheduler_if #(.audio_width(W)) bus ();

  serial_audio_channel_scheduler #(.audio_width(W), .fifo_depth_log2(FIFO_LOG2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .fill_repeat(fill_repeat),
    .bus(bus),
    .fill_strobe(fill_strobe)
`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
    ,
    .fill_count(fill_count)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] got_audio [16];
  logic         got_left  [16];
  int           nhs;
  int           nstrobe;

  typedef struct {
    logic         fill_repeat;
    logic [W-1:0] l0;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] exp_l1;
    int           exp_strobes;
  } vec_t;

  vec_t tbl [3];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    enable      = 1'b0;
    fill_repeat = FILL_ZERO;
    bus.l_valid = 1'b0;
    bus.l_audio = '0;
    bus.r_valid = 1'b0;
    bus.r_audio = '0;
    bus.o_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic push_one(input bit left, input logic [W-1:0] d);
    bit done = 1'b0;
    if (left) begin bus.l_valid = 1'b1; bus.l_audio = d; end
    else      begin bus.r_valid = 1'b1; bus.r_audio = d; end
    for (int i = 0; i < 50 && !done; i++) begin
      if (left ? bus.l_ready : bus.r_ready) done = 1'b1;
      step();
    end
    if (left) bus.l_valid = 1'b0;
    else      bus.r_valid = 1'b0;
    check(left ? "push_l_accept" : "push_r_accept", W'(done), W'(1));
  endtask

  task automatic collect(input int n, input int budget);
    nhs     = 0;
    nstrobe = 0;
    for (int i = 0; i < budget && nhs < n; i++) begin
      if (fill_strobe) nstrobe++;
      if (bus.o_valid && bus.o_ready) begin
        got_left[nhs]  = bus.o_is_left;
        got_audio[nhs] = bus.o_audio;
        nhs++;
      end
      step();
    end
    check("collect_count", W'(nhs), W'(n));
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30 && !bus.o_valid; i++) step();
    check(name, W'(bus.o_valid), W'(1));
  endtask

  // Reference model: per-channel queues, strict L/R turns, fill when a turn finds its queue empty
  task automatic random_run(input logic fr, input int cycles);
    logic [W-1:0] ql[$];
    logic [W-1:0] qr[$];
    logic [W-1:0] last_l, last_r, exp_audio;
    bit presenting, next_left, exp_left, was_fill, started, running, pl, pr, hs, rdy_l, rdy_r;
    int load_in;
    do_reset();
    fill_repeat = fr;
    enable      = 1'b1;
    running = 0; started = 0; presenting = 0; next_left = 1; exp_left = 0;
    load_in = -1; last_l = '0; last_r = '0; exp_audio = '0;
    for (int c = 0; c < cycles; c++) begin
      bus.l_valid = ($urandom_range(0, 99) < 35);
      bus.l_audio = $urandom();
      bus.r_valid = ($urandom_range(0, 99) < 55);
      bus.r_audio = $urandom();
      bus.o_ready = $urandom_range(0, 1) == 1;
      rdy_l = running && (ql.size() < DEPTH);
      rdy_r = running && (qr.size() < DEPTH);
      check("rnd_l_ready", W'(bus.l_ready), W'(rdy_l));
      check("rnd_r_ready", W'(bus.r_ready), W'(rdy_r));
      pl = bus.l_valid && rdy_l;
      pr = bus.r_valid && rdy_r;
      hs = presenting && bus.o_ready;
      step();
      was_fill = 0;
      if (load_in == 1) begin
        exp_left   = next_left;
        presenting = 1;
        load_in    = -1;
        if (next_left) begin
          if (ql.size() > 0) begin exp_audio = ql.pop_front(); last_l = exp_audio; end
          else begin was_fill = 1; exp_audio = fr ? last_l : '0; end
        end else begin
          if (qr.size() > 0) begin exp_audio = qr.pop_front(); last_r = exp_audio; end
          else begin was_fill = 1; exp_audio = fr ? last_r : '0; end
        end
      end else if (load_in > 1) begin
        load_in--;
      end
      if (hs) begin
        presenting = 0;
        next_left  = !next_left;
        load_in    = 1;
      end
      if (pl) ql.push_back(bus.l_audio);
      if (pr) qr.push_back(bus.r_audio);
      running = 1;
      if (!started && ql.size() > 0 && qr.size() > 0) begin
        started = 1;
        load_in = 2;
      end
      check("rnd_o_valid", W'(bus.o_valid), W'(presenting));
      check("rnd_fill_strobe", W'(fill_strobe), W'(was_fill));
      if (presenting) begin
        check("rnd_o_is_left", W'(bus.o_is_left), W'(exp_left));
        check("rnd_o_audio", bus.o_audio, exp_audio);
      end
    end
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
  endtask

  initial begin
    int li, ri, unstable;
    bit lacc, racc;

    tbl[0] = '{1'b1, 32'hAAA7AAA3, 32'hAAA80AA4, 32'h0BADF00D, 32'hAAA7AAA3, 1};
    tbl[1] = '{1'b0, 32'hAAA7AAA3, 32'hAAA80AA4, 32'h0BADF00D, 32'h00000000, 1};
    tbl[2] = '{1'b1, 32'h13579BDF, 32'h2468ACE0, 32'h55AA55AA, 32'h13579BDF, 1};

    // Reset values and start latency
    do_reset();
    check("rst_o_valid", W'(bus.o_valid), W'(0));
    check("rst_o_is_left", W'(bus.o_is_left), W'(0));
    check("rst_o_audio", bus.o_audio, '0);
    check("rst_l_ready", W'(bus.l_ready), W'(0));
    check("rst_r_ready", W'(bus.r_ready), W'(0));
    check("rst_fill_strobe", W'(fill_strobe), W'(0));
    enable      = 1'b1;
    bus.o_ready = 1'b1;
    step();
    check("en_l_ready", W'(bus.l_ready), W'(1));
    check("en_r_ready", W'(bus.r_ready), W'(1));
    push_one(1'b1, 32'hAAA7AAA3);
    push_one(1'b0, 32'hAAA80AA4);
    check("lat_c1_valid", W'(bus.o_valid), W'(0));
    step();
    check("lat_c2_valid", W'(bus.o_valid), W'(0));
    step();
    check("lat_c3_valid", W'(bus.o_valid), W'(1));
    check("lat_c3_left", W'(bus.o_is_left), W'(1));
    check("lat_c3_audio", bus.o_audio, 32'hAAA7AAA3);
    check("lat_c3_strobe", W'(fill_strobe), W'(0));
    step();
    check("lat_turn_gap", W'(bus.o_valid), W'(0));
    step();
    check("lat_r_valid", W'(bus.o_valid), W'(1));
    check("lat_r_left", W'(bus.o_is_left), W'(0));
    check("lat_r_audio", bus.o_audio, 32'hAAA80AA4);
    check("lat_r_strobe", W'(fill_strobe), W'(0));

    // Table: left stalls after one sample, fill policy decides the next left slot
    for (int i = 0; i < 3; i++) begin
      do_reset();
      fill_repeat = tbl[i].fill_repeat;
      enable      = 1'b1;
      bus.o_ready = 1'b1;
      step();
      push_one(1'b1, tbl[i].l0);
      push_one(1'b0, tbl[i].r0);
      push_one(1'b0, tbl[i].r1);
      collect(4, 60);
      check("tbl_s0_left", W'(got_left[0]), W'(1));
      check("tbl_s0_audio", got_audio[0], tbl[i].l0);
      check("tbl_s1_left", W'(got_left[1]), W'(0));
      check("tbl_s1_audio", got_audio[1], tbl[i].r0);
      check("tbl_s2_left", W'(got_left[2]), W'(1));
      check("tbl_s2_audio", got_audio[2], tbl[i].exp_l1);
      check("tbl_s3_left", W'(got_left[3]), W'(0));
      check("tbl_s3_audio", got_audio[3], tbl[i].r1);
      check("tbl_strobes", W'(nstrobe), W'(tbl[i].exp_strobes));
`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
      check("tbl_fill_count", W'(fill_count), W'(tbl[i].exp_strobes));
`endif
    end

    // Disable while a left sample is presented: the right half still goes out, then IDLE
    do_reset();
    enable      = 1'b1;
    bus.o_ready = 1'b0;
    step();
    push_one(1'b1, 32'h10);
    push_one(1'b0, 32'h20);
    push_one(1'b1, 32'h11);
    push_one(1'b0, 32'h21);
    wait_valid("dis_wait_valid");
    check("dis_pres_left", W'(bus.o_is_left), W'(1));
    enable      = 1'b0;
    bus.o_ready = 1'b1;
    collect(2, 20);
    check("dis_s0_audio", got_audio[0], 32'h10);
    check("dis_s1_left", W'(got_left[1]), W'(0));
    check("dis_s1_audio", got_audio[1], 32'h20);
    for (int i = 0; i < 4; i++) step();
    check("dis_idle_valid", W'(bus.o_valid), W'(0));
    check("dis_idle_l_ready", W'(bus.l_ready), W'(0));
    check("dis_idle_r_ready", W'(bus.r_ready), W'(0));
    enable = 1'b1;
    step();
    push_one(1'b1, 32'h77);
    push_one(1'b0, 32'h88);
    collect(1, 20);
    check("dis_restart_left", W'(got_left[0]), W'(1));
    check("dis_restart_audio", got_audio[0], 32'h77);

    // Encoder stalled for 100 cycles with both sources always valid
    do_reset();
    enable      = 1'b1;
    bus.o_ready = 1'b0;
    step();
    li = 0; ri = 0; unstable = 0;
    bus.l_valid = 1'b1; bus.l_audio = 32'h1000_0000;
    bus.r_valid = 1'b1; bus.r_audio = 32'h2000_0000;
    for (int c = 0; c < 100; c++) begin
      lacc = bus.l_ready;
      racc = bus.r_ready;
      if (bus.o_valid && (bus.o_audio !== 32'h1000_0000 || bus.o_is_left !== 1'b1)) unstable++;
      step();
      if (lacc) begin li++; bus.l_audio = 32'h1000_0000 + W'(li); end
      if (racc) begin ri++; bus.r_audio = 32'h2000_0000 + W'(ri); end
    end
    check("bp_l_accepts", W'(li), W'(DEPTH + 1));
    check("bp_r_accepts", W'(ri), W'(DEPTH));
    check("bp_unstable", W'(unstable), W'(0));
    check("bp_l_ready", W'(bus.l_ready), W'(0));
    check("bp_r_ready", W'(bus.r_ready), W'(0));
    check("bp_o_valid", W'(bus.o_valid), W'(1));
    bus.l_valid = 1'b0;
    bus.r_valid = 1'b0;
    bus.o_ready = 1'b1;
    collect(2 * DEPTH + 1, 80);
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      check("bp_drain_left", W'(got_left[k]), W'((k % 2) == 0));
      check("bp_drain_audio", got_audio[k],
            ((k % 2) == 0) ? (32'h1000_0000 + W'(k / 2)) : (32'h2000_0000 + W'(k / 2)));
    end
    check("bp_drain_strobes", W'(nstrobe), W'(0));

    // Asynchronous reset while presenting, then a clean restart on left
    do_reset();
    enable      = 1'b1;
    bus.o_ready = 1'b0;
    step();
    push_one(1'b1, 32'hA1);
    push_one(1'b0, 32'hB1);
    wait_valid("ar_wait_valid");
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_o_valid", W'(bus.o_valid), W'(0));
    check("ar_o_is_left", W'(bus.o_is_left), W'(0));
    check("ar_o_audio", bus.o_audio, '0);
    check("ar_l_ready", W'(bus.l_ready), W'(0));
    check("ar_r_ready", W'(bus.r_ready), W'(0));
    check("ar_fill_strobe", W'(fill_strobe), W'(0));
`ifdef SERIAL_AUDIO_SCHEDULER_STATS_EN
    check("ar_fill_count", W'(fill_count), W'(0));
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();
    push_one(1'b1, 32'hA2);
    push_one(1'b0, 32'hB2);
    bus.o_ready = 1'b1;
    collect(2, 20);
    check("ar_s0_left", W'(got_left[0]), W'(1));
    check("ar_s0_audio", got_audio[0], 32'hA2);
    check("ar_s1_left", W'(got_left[1]), W'(0));
    check("ar_s1_audio", got_audio[1], 32'hB2);

    // Randomized traffic under both fill policies
    random_run(FILL_REPEAT, 500);
    random_run(FILL_ZERO, 500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
